pagerank_scatter: RTL
=====================

# pagerank_scatter

Scatter-phase engine for the PageRank datapath. It walks a stream of (src, dest) edges, computes each edge's contribution as the current source rank divided by the source out-degree, and emits (page_rank_scatter, dest_id, pagerank_ready) beats. The local-update accumulator consumes these beats. It signals scatter_operation_complete once the last edge of a pass has been emitted.

## Interface
Parameters:
- NODES_IN_GRAPH, 32, number of nodes; valid ids are 0..NODES_IN_GRAPH-1

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a pass; honoured only in IDLE or DONE
- edge_valid  in  1  edge stream valid
- edge_ready  out  1  edge stream ready; high only in FETCH
- edge_src  in  32  source node id
- edge_dest  in  32  destination node id
- edge_last  in  1  marks the final edge of the pass
- pagerank_current  in  64 x NODES_IN_GRAPH  current ranks, unsigned Q32.32, stable for the whole pass
- out_degree  in  32 x NODES_IN_GRAPH  out-degree per node, stable for the whole pass
- page_rank_scatter  out  64  contribution value
- dest_id  out  32  destination of the contribution
- pagerank_ready  out  1  one-cycle strobe; the consumer accepts every strobe, so there is no backpressure
- scatter_operation_complete  out  1  level; high in DONE
- busy  out  1  high in FETCH, DIVIDE and EMIT
- degree_error  out  1  sticky; set when an edge's source has out_degree 0
- id_error  out  1  sticky; set when edge_src or edge_dest is >= NODES_IN_GRAPH

## Operation
- States: IDLE, FETCH, DIVIDE, EMIT, DONE.
- IDLE or DONE + start: go to FETCH. Clear scatter_operation_complete, degree_error, id_error and the cache-valid flag.
- FETCH: edge_ready=1. On edge_valid, latch src, dest and last. Then:
  - id out of range: set id_error and drop the edge. Go to DONE if last, else stay in FETCH.
  - degree 0: quotient=0, set degree_error, go to EMIT.
  - cache hit (cache_valid and src==cached_src): reuse cached quotient, go to EMIT.
  - otherwise: start the divider and go to DIVIDE.
- DIVIDE: wait for divider done. Then store the quotient, set cached_src=src and cache_valid=1, and go to EMIT.
- EMIT: register page_rank_scatter=quotient, dest_id=dest, pagerank_ready=1 for exactly one cycle. Go to DONE if last, else FETCH.
- DONE: hold scatter_operation_complete=1 until the next start.
- Arithmetic: quotient = rank / degree, unsigned, truncated toward zero. The 64-bit dividend and zero-extended 32-bit divisor give a 64-bit quotient, which cannot overflow.
- start while busy is ignored. edge_valid outside FETCH is ignored; the edge is not consumed.
- page_rank_scatter and dest_id hold their last value between strobes.

## Timing
- Reset values: all outputs 0, state IDLE, cache invalid, divider idle.
- Reset asserted mid-pass aborts immediately. No strobe is issued and complete is not set.
- Edge accepted at cycle t:
  - cache miss: DIVIDE occupies t+1..t+64 and pagerank_ready is high in cycle t+65.
  - cache hit or degree 0: pagerank_ready is high in cycle t+1.
- After EMIT, FETCH is entered the next cycle. Best-case throughput is one edge per 2 cycles.
- Last edge emitted in cycle e: scatter_operation_complete rises in cycle e+1.
- Last edge dropped (id error) in cycle t: scatter_operation_complete rises in cycle t+1 with no strobe.
- start in cycle s: busy and edge_ready go high in cycle s+1.

## Structure
- Package pagerank_pkg contains:
  - rank_t (logic [63:0]), node_id_t (logic [31:0]), degree_t (logic [31:0])
  - state enum scatter_state_t
  - DIV_CYCLES = 64
- Sub-module pagerank_divider: restoring sequential divider producing one quotient bit per cycle.
  - Inputs: start, 64-bit dividend, 32-bit divisor.
  - Outputs: 64-bit quotient, done pulse.
  - Takes exactly DIV_CYCLES cycles and is reset by reset_n.

## Test plan
- Single edge, rank[0]=0x0000_0001_0000_0000, deg[0]=4, edge 0->1 last: strobe at t+65 with value 0x0000_0000_4000_0000 and dest_id=1; complete in the next cycle.
- Cache reuse: edges 0->1, 0->2, 0->3 with the same ranks. The first strobe is at t+65; the second and third each arrive 1 cycle after their acceptance, with value 0x4000_0000 and dests 2 and 3.
- Truncation: rank=7, deg=2 gives 3. Then rank=0xFFFF_FFFF_FFFF_FFFF, deg=1 gives the same value unchanged.
- Errors:
  - deg[5]=0, edge 5->0: strobe value 0 and degree_error=1.
  - edge 40->0 (N=32) as last: no strobe, id_error=1, complete=1.
  - The next start clears both flags.
- Reset and start handling:
  - Assert reset_n=0 during DIVIDE: all outputs 0; a new pass afterward behaves normally with no stale cache hit.
  - start pulsed while busy: no effect.
  - edge_valid held high in IDLE: no edge consumed.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types and constants for the PageRank scatter engine.
package pagerank_pkg;

    typedef logic [63:0] rank_t;     // unsigned Q32.32 rank / contribution
    typedef logic [31:0] node_id_t;
    typedef logic [31:0] degree_t;

    // Quotient bits produced by the sequential divider, one per cycle.
    localparam int DIV_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DIVIDE,
        EMIT,
        DONE
    } scatter_state_t;

endpackage

// File: rtl/pagerank_scatter_if.sv
// Edge stream in, contribution beats out. The engine sits on the slave side.
interface pagerank_scatter_if;
    import pagerank_pkg::*;

    logic     edge_valid;
    logic     edge_ready;
    node_id_t edge_src;
    node_id_t edge_dest;
    logic     edge_last;

    rank_t    page_rank_scatter;
    node_id_t dest_id;
    logic     pagerank_ready;

    modport master (
        output edge_valid, edge_src, edge_dest, edge_last,
        input  edge_ready, page_rank_scatter, dest_id, pagerank_ready
    );

    modport slave (
        input  edge_valid, edge_src, edge_dest, edge_last,
        output edge_ready, page_rank_scatter, dest_id, pagerank_ready
    );

endinterface

// File: rtl/pagerank_divider.sv
// Restoring divider: 64-bit dividend / 32-bit divisor, one quotient bit per
// cycle. The first bit is resolved on the start edge from the live operands,
// so the result is complete after DIV_CYCLES edges and done pulses the cycle after.
module pagerank_divider
    import pagerank_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    input  logic    start_i,
    input  rank_t   dividend_i,
    input  degree_t divisor_i,
    output rank_t   quotient_o,
    output logic    done_o
);

    localparam int               CNT_W     = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    degree_t          rem_q;
    degree_t          rem_d;
    rank_t            quo_q;
    rank_t            quo_d;
    degree_t          divisor_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;

    degree_t          rem_in;
    degree_t          div_in;
    rank_t            quo_in;
    logic [32:0]      trial;
    logic [32:0]      diff;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The remainder stays
    // below the divisor, so 33 bits cover the shifted trial value.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        rem_in = start_i ? '0 : rem_q;
        quo_in = start_i ? dividend_i : quo_q;
        div_in = start_i ? divisor_i : divisor_q;
        trial  = {rem_in, quo_in[63]};
        diff   = trial - {1'b0, div_in};
        rem_d  = trial[31:0];
        quo_d  = {quo_in[62:0], 1'b0};
        if (trial >= {1'b0, div_in}) begin
            rem_d    = diff[31:0];
            quo_d[0] = 1'b1;
        end
    end

    // Iteration state: quotient shifts in from the LSB as the dividend leaves the MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q     <= rem_d;
                quo_q     <= quo_d;
                divisor_q <= divisor_i;
                count_q   <= CNT_W'(1);
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                rem_q   <= rem_d;
                quo_q   <= quo_d;
                count_q <= count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/pagerank_scatter.sv
// Scatter engine: for each (src, dest) edge emit rank[src] / out_degree[src]
// toward dest. The most recent divided source is cached so runs of edges from
// one source cost a single division.
module pagerank_scatter
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_GRAPH = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    pagerank_scatter_if.slave            bus,
    input  rank_t   [NODES_IN_GRAPH-1:0] pagerank_current,
    input  degree_t [NODES_IN_GRAPH-1:0] out_degree,
    output logic                         scatter_operation_complete,
    output logic                         busy,
    output logic                         degree_error,
    output logic                         id_error
);

    localparam int       IDX_W     = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam node_id_t NODE_LIMIT = node_id_t'(NODES_IN_GRAPH);

    scatter_state_t state_q;
    scatter_state_t state_d;

    node_id_t src_q;
    node_id_t dest_q;
    logic     last_q;
    node_id_t cached_src_q;
    rank_t    cached_quot_q;
    logic     cache_valid_q;
    rank_t    scatter_q;
    node_id_t dest_id_q;
    logic     degree_error_q;
    logic     id_error_q;

    logic             accept;
    logic             id_ok;
    logic [IDX_W-1:0] src_idx;
    degree_t          fetch_degree;
    rank_t            fetch_rank;
    logic             cache_hit;

    logic     clear_pass;
    logic     set_id_err;
    logic     set_deg_err;
    logic     div_start;
    logic     div_store;
    logic     emit_load;
    rank_t    emit_value;
    node_id_t emit_dest;
    rank_t    div_quotient;
    logic     div_done;

    assign accept       = (state_q == FETCH) && bus.edge_valid;
    assign id_ok        = (bus.edge_src < NODE_LIMIT) && (bus.edge_dest < NODE_LIMIT);
    assign src_idx      = bus.edge_src[IDX_W-1:0];
    assign fetch_degree = out_degree[src_idx];
    assign fetch_rank   = pagerank_current[src_idx];
    assign cache_hit    = cache_valid_q && (bus.edge_src == cached_src_q);

    pagerank_divider u_divider (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (div_start),
        .dividend_i (fetch_rank),
        .divisor_i  (fetch_degree),
        .quotient_o (div_quotient),
        .done_o     (div_done)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control. The output beat is loaded on the
    // transition into EMIT so the strobe and its data appear together.
    always_comb begin
        state_d     = state_q;
        clear_pass  = 1'b0;
        set_id_err  = 1'b0;
        set_deg_err = 1'b0;
        div_start   = 1'b0;
        div_store   = 1'b0;
        emit_load   = 1'b0;
        emit_value  = '0;
        emit_dest   = dest_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear_pass = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (bus.edge_valid) begin
                    emit_dest = bus.edge_dest;
                    if (!id_ok) begin
                        set_id_err = 1'b1;
                        state_d    = bus.edge_last ? DONE : FETCH;
                    end else if (fetch_degree == '0) begin
                        set_deg_err = 1'b1;
                        emit_load   = 1'b1;
                        state_d     = EMIT;
                    end else if (cache_hit) begin
                        emit_load  = 1'b1;
                        emit_value = cached_quot_q;
                        state_d    = EMIT;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    div_store  = 1'b1;
                    emit_load  = 1'b1;
                    emit_value = div_quotient;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                state_d = last_q ? DONE : FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Edge capture, quotient cache, sticky error flags and the output beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q          <= '0;
            dest_q         <= '0;
            last_q         <= 1'b0;
            cached_src_q   <= '0;
            cached_quot_q  <= '0;
            cache_valid_q  <= 1'b0;
            scatter_q      <= '0;
            dest_id_q      <= '0;
            degree_error_q <= 1'b0;
            id_error_q     <= 1'b0;
        end else begin
            if (clear_pass) begin
                cache_valid_q  <= 1'b0;
                degree_error_q <= 1'b0;
                id_error_q     <= 1'b0;
            end
            if (accept) begin
                src_q  <= bus.edge_src;
                dest_q <= bus.edge_dest;
                last_q <= bus.edge_last;
            end
            if (set_id_err) begin
                id_error_q <= 1'b1;
            end
            if (set_deg_err) begin
                degree_error_q <= 1'b1;
            end
            if (div_store) begin
                cached_quot_q <= div_quotient;
                cached_src_q  <= src_q;
                cache_valid_q <= 1'b1;
            end
            if (emit_load) begin
                scatter_q <= emit_value;
                dest_id_q <= emit_dest;
            end
        end
    end

    assign bus.edge_ready             = (state_q == FETCH);
    assign bus.pagerank_ready         = (state_q == EMIT);
    assign bus.page_rank_scatter      = scatter_q;
    assign bus.dest_id                = dest_id_q;
    assign busy                       = (state_q == FETCH) || (state_q == DIVIDE) || (state_q == EMIT);
    assign scatter_operation_complete = (state_q == DONE);
    assign degree_error               = degree_error_q;
    assign id_error                   = id_error_q;

endmodule
